// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin arbiter that shares the io_master AR/R read
// channels between the icache refill path (s0) and the LSU load path (s1).
// A grant lasts one whole transaction, from the AR handshake to the rlast beat.
// Optional feature macro: AXI_RD_ARB_TIMEOUT_EN adds an R-phase watchdog that
// returns a synthesized SLVERR beat to the owner when io_master stops responding.
module axi_read_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    // requester 0: icache refill
    input  logic          s0_arvalid,
    output logic          s0_arready,
    input  logic [AW-1:0] s0_araddr,
    input  logic [3:0]    s0_arid,
    input  logic [7:0]    s0_arlen,
    input  logic [2:0]    s0_arsize,
    input  logic [1:0]    s0_arburst,
    output logic          s0_rvalid,
    input  logic          s0_rready,
    output logic [DW-1:0] s0_rdata,
    output logic [1:0]    s0_rresp,
    output logic [3:0]    s0_rid,
    output logic          s0_rlast,
    // requester 1: LSU loads
    input  logic          s1_arvalid,
    output logic          s1_arready,
    input  logic [AW-1:0] s1_araddr,
    input  logic [3:0]    s1_arid,
    input  logic [7:0]    s1_arlen,
    input  logic [2:0]    s1_arsize,
    input  logic [1:0]    s1_arburst,
    output logic          s1_rvalid,
    input  logic          s1_rready,
    output logic [DW-1:0] s1_rdata,
    output logic [1:0]    s1_rresp,
    output logic [3:0]    s1_rid,
    output logic          s1_rlast,
    // io_master read port
    output logic          m_arvalid,
    input  logic          m_arready,
    output logic [AW-1:0] m_araddr,
    output logic [3:0]    m_arid,
    output logic [7:0]    m_arlen,
    output logic [2:0]    m_arsize,
    output logic [1:0]    m_arburst,
    input  logic          m_rvalid,
    output logic          m_rready,
    input  logic [DW-1:0] m_rdata,
    input  logic [1:0]    m_rresp,
    input  logic [3:0]    m_rid,
    input  logic          m_rlast
);

`ifdef AXI_RD_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_RWAIT, ST_ERR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_RWAIT} state_t;
`endif

    state_t r_state, w_state_next;
    logic   r_owner, w_owner_next;
    logic   r_last_grant, w_last_grant_next;
    logic   w_winner;
    logic   w_own_arvalid;
    logic   w_own_rready;
    logic   w_to_hit;

    // On a tie the requester that did not win last time gets the port.
    assign w_winner      = (s0_arvalid && s1_arvalid) ? ~r_last_grant : s1_arvalid;
    assign w_own_arvalid = r_owner ? s1_arvalid : s0_arvalid;
    assign w_own_rready  = r_owner ? s1_rready  : s0_rready;

`ifdef AXI_RD_ARB_TIMEOUT_EN
    logic [TO_W-1:0] r_wdog, w_wdog_next;
    logic [3:0]      r_err_id, w_err_id_next;

    assign w_to_hit = (r_state == ST_RWAIT) && (r_wdog == TO_W'(TIMEOUT));

    // Watchdog: cleared when the address is accepted and on every R beat.
    always_comb begin
        w_wdog_next   = r_wdog;
        w_err_id_next = r_err_id;
        if (r_state == ST_AR) begin
            w_wdog_next = '0;
            if (w_own_arvalid && m_arready)
                w_err_id_next = r_owner ? s1_arid : s0_arid;
        end else if (r_state == ST_RWAIT) begin
            if (m_rvalid && m_rready) w_wdog_next = '0;
            else                      w_wdog_next = r_wdog + 1'b1;
        end
    end

    // Watchdog and error-id registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog   <= '0;
            r_err_id <= '0;
        end else begin
            r_wdog   <= w_wdog_next;
            r_err_id <= w_err_id_next;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // Next-state logic and channel routing toward the current owner.
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_grant_next = r_last_grant;
        s0_arready = 1'b0;  s1_arready = 1'b0;
        s0_rvalid  = 1'b0;  s1_rvalid  = 1'b0;
        s0_rdata   = '0;    s1_rdata   = '0;
        s0_rresp   = '0;    s1_rresp   = '0;
        s0_rid     = '0;    s1_rid     = '0;
        s0_rlast   = 1'b0;  s1_rlast   = 1'b0;
        m_arvalid  = 1'b0;
        m_araddr   = '0;
        m_arid     = '0;
        m_arlen    = '0;
        m_arsize   = '0;
        m_arburst  = '0;
        m_rready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    w_owner_next      = w_winner;
                    w_last_grant_next = w_winner;
                    w_state_next      = ST_AR;
                end
            end
            ST_AR: begin
                m_arvalid = w_own_arvalid;
                if (r_owner) begin
                    m_araddr   = s1_araddr;
                    m_arid     = s1_arid;
                    m_arlen    = s1_arlen;
                    m_arsize   = s1_arsize;
                    m_arburst  = s1_arburst;
                    s1_arready = m_arready;
                end else begin
                    m_araddr   = s0_araddr;
                    m_arid     = s0_arid;
                    m_arlen    = s0_arlen;
                    m_arsize   = s0_arsize;
                    m_arburst  = s0_arburst;
                    s0_arready = m_arready;
                end
                if (w_own_arvalid && m_arready) w_state_next = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (w_to_hit) begin
`ifdef AXI_RD_ARB_TIMEOUT_EN
                    w_state_next = ST_ERR;
`endif
                end else begin
                    m_rready = w_own_rready;
                    if (r_owner) begin
                        s1_rvalid = m_rvalid;
                        s1_rdata  = m_rdata;
                        s1_rresp  = m_rresp;
                        s1_rid    = m_rid;
                        s1_rlast  = m_rlast;
                    end else begin
                        s0_rvalid = m_rvalid;
                        s0_rdata  = m_rdata;
                        s0_rresp  = m_rresp;
                        s0_rid    = m_rid;
                        s0_rlast  = m_rlast;
                    end
                    // Only rlast ends the transaction; arlen is never counted.
                    if (m_rvalid && w_own_rready && m_rlast) w_state_next = ST_IDLE;
                end
            end
`ifdef AXI_RD_ARB_TIMEOUT_EN
            ST_ERR: begin
                if (r_owner) begin
                    s1_rvalid = 1'b1;
                    s1_rresp  = 2'b10;
                    s1_rid    = r_err_id;
                    s1_rlast  = 1'b1;
                end else begin
                    s0_rvalid = 1'b1;
                    s0_rresp  = 2'b10;
                    s0_rid    = r_err_id;
                    s0_rlast  = 1'b1;
                end
                if (w_own_rready) w_state_next = ST_IDLE;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
        end
    end

endmodule
